// File: rtl/ahb2apb_rst_pkg.sv
// ---------------------------------------------------------------------------
// ahb2apb_rst_pkg
// Shared types and defaults for the AHB2APB reset-domain sequencer.
//   rst_seq_state_e : sequencer FSM states
//   *_DEF           : default parameter values used by rst_seq_ctrl
//   cnt_width()     : width of the shared filter/hold/gap cycle counter
// ---------------------------------------------------------------------------
package ahb2apb_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILTER  = 2'd1,
        HOLD    = 2'd2,
        REL_APB = 2'd3
    } rst_seq_state_e;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int FILTER_CYCLES_DEF = 2;
    localparam int HOLD_CYCLES_DEF   = 8;
    localparam int GAP_CYCLES_DEF    = 4;
    localparam int CNT_W_DEF         = 8;

    // One counter serves all three timed states. It must hold the largest
    // limit plus one so the look-ahead increment never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl_if
// Bundle between the reset sequencer and its environment.
//   rst_req   : raw active-high reset request (asynchronous to clk)
//   apb_rst_n : active-low APB-side reset
//   ahb_rst_n : active-low AHB-side reset
//   seq_busy  : sequence in progress
//   rst_done  : one-cycle pulse when ahb_rst_n releases
//   rst_count : accepted request count (only with RST_SEQ_CNT_EN defined)
// Modports: master = sequencer side, slave = requester/observer side.
// Optional feature macro: RST_SEQ_CNT_EN (adds CNT_W and rst_count).
// ---------------------------------------------------------------------------
interface rst_seq_ctrl_if
    import ahb2apb_rst_pkg::*;
`ifdef RST_SEQ_CNT_EN
#(
    parameter int CNT_W = CNT_W_DEF
)
`endif
;
    logic rst_req;
    logic apb_rst_n;
    logic ahb_rst_n;
    logic seq_busy;
    logic rst_done;
`ifdef RST_SEQ_CNT_EN
    logic [CNT_W-1:0] rst_count;

    modport master (
        input  rst_req,
        output apb_rst_n, ahb_rst_n, seq_busy, rst_done, rst_count
    );

    modport slave (
        output rst_req,
        input  apb_rst_n, ahb_rst_n, seq_busy, rst_done, rst_count
    );
`else
    modport master (
        input  rst_req,
        output apb_rst_n, ahb_rst_n, seq_busy, rst_done
    );

    modport slave (
        output rst_req,
        input  apb_rst_n, ahb_rst_n, seq_busy, rst_done
    );
`endif

endinterface

// File: rtl/rst_sync.sv
// ---------------------------------------------------------------------------
// rst_sync
// Multi-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   clr_n : synchronous active-low clear of the whole chain
//   d     : asynchronous input
//   q     : synchronized output (last stage)
// Parameter STAGES (>= 2) sets the chain length.
// ---------------------------------------------------------------------------
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: flop state is always written with <= so every stage samples the
    // previous stage's old value; with = the chain would collapse to one flop.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
// Reset-domain sequencer for the AHB2APB bridge. A raw reset request is
// synchronized and glitch-filtered, then both resets are held low and
// released in order: APB side first, AHB side GAP_CYCLES later.
//   clk     : single rising-edge clock
//   reset_n : synchronous active-low power-on reset
//   bus     : rst_seq_ctrl_if.master (rst_req in; apb_rst_n, ahb_rst_n,
//             seq_busy, rst_done and optional rst_count out)
// Optional feature macro: RST_SEQ_CNT_EN (saturating accepted-request count).
// ---------------------------------------------------------------------------
module rst_seq_ctrl
    import ahb2apb_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    rst_seq_ctrl_if.master bus
);

    localparam int            TW     = cnt_width(FILTER_CYCLES, HOLD_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] FILT_N = TW'(FILTER_CYCLES);
    localparam logic [TW-1:0] HOLD_N = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] GAP_N  = TW'(GAP_CYCLES);

    rst_seq_state_e state, state_nxt;
    logic [TW-1:0]  cnt, cnt_nxt, cnt_inc;
    logic           req_s;
    logic           apb_set, ahb_set, done_set;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .clr_n (reset_n),
        .d     (bus.rst_req),
        .q     (req_s)
    );

    assign cnt_inc = cnt + TW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output of this
        // block; a missing branch would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req_s) begin
                    state_nxt = FILTER;
                    cnt_nxt   = TW'(1);
                end
            end
            FILTER: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= FILT_N) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            HOLD: begin
                // The hold time only starts once the request has gone away.
                if (req_s) begin
                    cnt_nxt   = '0;
                end else if (cnt_inc >= HOLD_N) begin
                    state_nxt = REL_APB;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            REL_APB: begin
                // A new request during the gap re-asserts immediately and
                // wins over gap completion.
                if (req_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= GAP_N) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered decodes of the current state, so they trail the
    // state by one edge and never see rst_req combinationally.
    assign apb_set  = (state != HOLD);
    assign ahb_set  = (state == IDLE) || (state == FILTER);
    assign done_set = ahb_set && !bus.ahb_rst_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.apb_rst_n <= 1'b0;
            bus.ahb_rst_n <= 1'b0;
            bus.seq_busy  <= 1'b1;
            bus.rst_done  <= 1'b0;
        end else begin
            bus.apb_rst_n <= apb_set;
            bus.ahb_rst_n <= ahb_set;
            bus.rst_done  <= done_set;
            // Busy also covers the rst_done cycle so it drops one cycle later.
            bus.seq_busy  <= (state != IDLE) || done_set;
        end
    end

`ifdef RST_SEQ_CNT_EN
    localparam int CW = $bits(bus.rst_count);

    logic accept;
    assign accept = (state == FILTER) && (state_nxt == HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.rst_count <= '0;
        end else if (accept && (bus.rst_count != {CW{1'b1}})) begin
            bus.rst_count <= bus.rst_count + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Self-checking bench for rst_seq_ctrl. Every output edge the sequence must
// produce is pushed, with its expected clock-edge number, into a sorted
// scoreboard when the stimulus is driven; a negedge monitor pops and checks
// each observed output edge. With RST_SEQ_CNT_EN defined the request counter
// is checked too, including a CNT_W=2 instance for saturation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
    import ahb2apb_rst_pkg::*;

    localparam int SYNC  = 2;
    localparam int FILT  = 2;
    localparam int HOLDC = 8;
    localparam int GAP   = 4;

    typedef enum int {
        EV_APB_FALL  = 0,
        EV_AHB_FALL  = 1,
        EV_APB_RISE  = 2,
        EV_AHB_RISE  = 3,
        EV_DONE_RISE = 4,
        EV_DONE_FALL = 5,
        EV_BUSY_RISE = 6,
        EV_BUSY_FALL = 7
    } ev_e;

    typedef struct {
        int  cyc;
        ev_e kind;
    } ev_t;

    ev_t  sb_q[$];
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_bad     = 0;
    int   exp_count = 0;
    bit   mon_on    = 1'b0;
    logic prev_apb, prev_ahb, prev_done, prev_busy;

    rst_seq_ctrl_if bus ();

    rst_seq_ctrl #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .HOLD_CYCLES   (HOLDC),
        .GAP_CYCLES    (GAP)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef RST_SEQ_CNT_EN
    rst_seq_ctrl_if #(.CNT_W(2)) sat_bus ();
    assign sat_bus.rst_req = bus.rst_req;

    rst_seq_ctrl #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .HOLD_CYCLES   (HOLDC),
        .GAP_CYCLES    (GAP)
    ) u_dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sat_bus)
    );
`endif

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc reads n at the following negedge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic sb_push(input int c, input ev_e k);
        int idx;
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].cyc > c || (sb_q[i].cyc == c && sb_q[i].kind > k)) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, '{c, k});
    endtask

    task automatic sb_match(input ev_e k);
        if (sb_q.size() == 0) begin
            check($sformatf("unexpected_%s@%0d", k.name(), cyc), cyc, -1);
        end else if (sb_q[0].cyc > cyc) begin
            check($sformatf("early_%s", k.name()), cyc, sb_q[0].cyc);
        end else begin
            check($sformatf("event_kind@%0d", cyc), int'(k), int'(sb_q[0].kind));
            void'(sb_q.pop_front());
        end
    endtask

    // Output-edge monitor, sampling away from the active edge.
    always @(negedge clk) begin
        logic [7:0] det;
        if (mon_on) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check($sformatf("missed_%s", sb_q[0].kind.name()), cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            det = '0;
            det[EV_APB_FALL]  = prev_apb  && !bus.apb_rst_n;
            det[EV_AHB_FALL]  = prev_ahb  && !bus.ahb_rst_n;
            det[EV_APB_RISE]  = !prev_apb && bus.apb_rst_n;
            det[EV_AHB_RISE]  = !prev_ahb && bus.ahb_rst_n;
            det[EV_DONE_RISE] = !prev_done && bus.rst_done;
            det[EV_DONE_FALL] = prev_done && !bus.rst_done;
            det[EV_BUSY_RISE] = !prev_busy && bus.seq_busy;
            det[EV_BUSY_FALL] = prev_busy && !bus.seq_busy;
            for (int k = 0; k < 8; k++) begin
                if (det[k]) sb_match(ev_e'(k));
            end
            check("ahb_implies_apb", int'(bus.ahb_rst_n && !bus.apb_rst_n), 0);
        end
        prev_apb  = bus.apb_rst_n;
        prev_ahb  = bus.ahb_rst_n;
        prev_done = bus.rst_done;
        prev_busy = bus.seq_busy;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drive_req(input int len);
        bus.rst_req = 1'b1;
        repeat (len) @(negedge clk);
        bus.rst_req = 1'b0;
    endtask

    // Assertion path from IDLE; e0 is the first edge that samples rst_req=1.
    task automatic push_assert(input int e0);
        sb_push(e0 + SYNC + 1, EV_BUSY_RISE);
        sb_push(e0 + SYNC + FILT, EV_APB_FALL);
        sb_push(e0 + SYNC + FILT, EV_AHB_FALL);
    endtask

    // Release path; f is the first edge at which HOLD sees req_s=0.
    task automatic push_release(input int f, output int last);
        int a, b;
        a = f + HOLDC;
        b = a + GAP;
        sb_push(a, EV_APB_RISE);
        sb_push(b, EV_AHB_RISE);
        sb_push(b, EV_DONE_RISE);
        sb_push(b + 1, EV_DONE_FALL);
        sb_push(b + 1, EV_BUSY_FALL);
        last = b + 1;
    endtask

    task automatic check_count(input string tag);
`ifdef RST_SEQ_CNT_EN
        check({tag, "_rst_count"}, int'(bus.rst_count), exp_count);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_drain"}, sb_q.size(), 0);
        check({tag, "_idle_apb"}, int'(bus.apb_rst_n), 1);
        check({tag, "_idle_ahb"}, int'(bus.ahb_rst_n), 1);
        check({tag, "_idle_busy"}, int'(bus.seq_busy), 0);
        check_count(tag);
    endtask

    task automatic accept_req(input int len, input string tag);
        int e0, last;
        e0 = cyc + 1;
        push_assert(e0);
        push_release(e0 + len + SYNC, last);
        exp_count++;
        drive_req(len);
        wait_cyc(last + 2);
        check_idle(tag);
    endtask

    initial begin
        int e0, a, last;
        bus.rst_req = 1'b0;
        reset_n     = 1'b0;

        // Power-on reset state.
        repeat (3) @(negedge clk);
        check("por_apb_rst_n", int'(bus.apb_rst_n), 0);
        check("por_ahb_rst_n", int'(bus.ahb_rst_n), 0);
        check("por_seq_busy", int'(bus.seq_busy), 1);
        check("por_rst_done", int'(bus.rst_done), 0);
        check_count("por");

        // Release: full HOLD then GAP with rst_req low.
        mon_on  = 1'b1;
        reset_n = 1'b1;
        push_release(cyc + 1, last);
        wait_cyc(last + 2);
        check_idle("power_on");

        // Accepted request, 5 cycles wide.
        accept_req(5, "accept");

        // One-cycle glitch: only a FILTER visit shows on seq_busy.
        e0 = cyc + 1;
        sb_push(e0 + SYNC + 1, EV_BUSY_RISE);
        sb_push(e0 + 1 + SYNC + 1, EV_BUSY_FALL);
        drive_req(1);
        wait_cyc(e0 + 12);
        check_idle("glitch");

        // Re-request two cycles into REL_APB.
        e0 = cyc + 1;
        push_assert(e0);
        a = e0 + 5 + SYNC + HOLDC;
        sb_push(a, EV_APB_RISE);
        exp_count++;
        drive_req(5);
        wait_cyc(a - 1);
        e0 = cyc + 1;
        sb_push(e0 + SYNC + 1, EV_APB_FALL);
        push_release(e0 + 3 + SYNC, last);
        drive_req(3);
        wait_cyc(last + 2);
        check_idle("rerequest");

        // Reset pulse in the middle of HOLD restarts the full release.
        e0 = cyc + 1;
        push_assert(e0);
        exp_count++;
        drive_req(2);
        wait_cyc(e0 + 6);
        check_count("pre_midreset");
        check("midhold_apb_rst_n", int'(bus.apb_rst_n), 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        exp_count = 0;
        check("midreset_ahb_rst_n", int'(bus.ahb_rst_n), 0);
        push_release(cyc + 1, last);
        wait_cyc(last + 2);
        check_idle("midreset");

        // Back-to-back accepted requests; the CNT_W=2 copy saturates at 3.
        for (int k = 1; k <= 5; k++) begin
            accept_req(2, $sformatf("seq%0d", k));
`ifdef RST_SEQ_CNT_EN
            check($sformatf("sat_count_%0d", k), int'(sat_bus.rst_count),
                  (exp_count > 3) ? 3 : exp_count);
`endif
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
